// File: rtl/cam_pkg.sv
// Shared state type, default geometry and width helper for the camera capture front-end.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } cam_state_e;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    function automatic int pix_width(input int data_w, input int bytes_per_pix);
        return data_w * bytes_per_pix;
    endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Gathers BYTES_PER_PIX camera bytes MSB-first into one pixel word; flush drops a partial pixel.
module cam_byte_packer
    import cam_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int BYTES_PER_PIX = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        flush_i,
    input  logic                                        byte_en_i,
    input  logic [DATA_W-1:0]                           byte_i,
    output logic                                        pix_done_o,
    output logic                                        partial_o,
    output logic [pix_width(DATA_W, BYTES_PER_PIX)-1:0] pix_word_o
);

    localparam int PW    = pix_width(DATA_W, BYTES_PER_PIX);
    localparam int CNT_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_PIX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    shift_q, shift_d;

    // The word is completed combinationally so the pixel can be registered on the same edge.
    assign pix_word_o = (shift_q << DATA_W) | PW'(byte_i);
    assign pix_done_o = byte_en_i && (cnt_q == CNT_LAST);
    assign partial_o  = (cnt_q != '0);

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (flush_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_en_i) begin
            shift_d = pix_word_o;
            cnt_d   = pix_done_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/camera_capture.sv
// DVP camera capture: registers the pins, packs bytes into pixels, tags position and frame markers.
//   state   | meaning
//   IDLE    | disarmed; arms on shutter rise, or at once when CONTINUOUS
//   WAIT_VS | armed; waits for vsync fall so only whole frames are captured
//   ACTIVE  | capturing lines until vsync rises
//   DONE    | one-cycle frame_done and final row-count check
module camera_capture
    import cam_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int CONTINUOUS    = 0
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        cam_href,
    input  logic                                        cam_vsync,
    input  logic [DATA_W-1:0]                           cam_data,
    input  logic                                        shutter_sw,
    output logic                                        pix_valid,
    output logic [pix_width(DATA_W, BYTES_PER_PIX)-1:0] pix_data,
    output logic [$clog2(H_ACTIVE)-1:0]                 pix_col,
    output logic [$clog2(V_ACTIVE)-1:0]                 pix_row,
    output logic                                        pix_sof,
    output logic                                        pix_eol,
    output logic                                        frame_done,
    output logic                                        busy,
    output logic                                        err_line,
    output logic                                        err_frame
);

    localparam int PW    = pix_width(DATA_W, BYTES_PER_PIX);
    localparam int COL_W = $clog2(H_ACTIVE);
    localparam int ROW_W = $clog2(V_ACTIVE);
    localparam int CC_W  = $clog2(H_ACTIVE + 1);
    localparam int RC_W  = $clog2(V_ACTIVE + 1);
    localparam logic [CC_W-1:0] H_END  = CC_W'(H_ACTIVE);
    localparam logic [CC_W-1:0] H_LAST = CC_W'(H_ACTIVE - 1);
    localparam logic [RC_W-1:0] V_END  = RC_W'(V_ACTIVE);

    logic              href_q, href_p_q, vsync_q, vsync_p_q, shut_q, shut_p_q;
    logic [DATA_W-1:0] data_q;
    logic              vs_fall, vs_rise, href_fall, shut_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            href_q    <= 1'b0;
            href_p_q  <= 1'b0;
            vsync_q   <= 1'b0;
            vsync_p_q <= 1'b0;
            shut_q    <= 1'b0;
            shut_p_q  <= 1'b0;
            data_q    <= '0;
        end else begin
            href_q    <= cam_href;
            href_p_q  <= href_q;
            vsync_q   <= cam_vsync;
            vsync_p_q <= vsync_q;
            shut_q    <= shutter_sw;
            shut_p_q  <= shut_q;
            data_q    <= cam_data;
        end
    end

    assign vs_fall   = vsync_p_q & ~vsync_q;
    assign vs_rise   = ~vsync_p_q & vsync_q;
    assign href_fall = href_p_q & ~href_q;
    assign shut_rise = shut_q & ~shut_p_q;

    cam_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if ((CONTINUOUS != 0) || shut_rise) state_d = WAIT_VS;
            WAIT_VS: if (vs_fall) state_d = ACTIVE;
            ACTIVE:  if (vs_rise) state_d = DONE;
            DONE:    state_d = (CONTINUOUS != 0) ? WAIT_VS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    logic          byte_en, line_end, start_frame, arm_new;
    logic          pk_done, pk_partial;
    logic [PW-1:0] pk_word;

    // ACTIVE is only ever entered with vsync low, so href during blanking never reaches the packer.
    assign byte_en     = (state_q == ACTIVE) && href_q;
    assign line_end    = (state_q == ACTIVE) && href_fall;
    assign start_frame = (state_q == WAIT_VS) && vs_fall;
    assign arm_new     = (state_q == IDLE) && (state_d == WAIT_VS);

    cam_byte_packer #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (start_frame || line_end),
        .byte_en_i  (byte_en),
        .byte_i     (data_q),
        .pix_done_o (pk_done),
        .partial_o  (pk_partial),
        .pix_word_o (pk_word)
    );

    logic [CC_W-1:0]  col_q, col_d;
    logic [RC_W-1:0]  row_q, row_d;
    logic [PW-1:0]    pix_data_q, pix_data_d;
    logic [COL_W-1:0] pix_col_q, pix_col_d;
    logic [ROW_W-1:0] pix_row_q, pix_row_d;
    logic             pix_valid_q, pix_valid_d, sof_q, sof_d, eol_q, eol_d;
    logic             err_line_q, err_line_d, err_frame_q, err_frame_d;
    logic             col_over, row_over;

    assign col_over = (col_q >= H_END);
    assign row_over = (row_q >= V_END);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pix_valid_d = 1'b0;
        sof_d       = 1'b0;
        eol_d       = 1'b0;
        pix_data_d  = pix_data_q;
        pix_col_d   = pix_col_q;
        pix_row_d   = pix_row_q;
        err_line_d  = err_line_q;
        err_frame_d = err_frame_q;

        if (arm_new) begin
            err_line_d  = 1'b0;
            err_frame_d = 1'b0;
        end
        if (start_frame) begin
            col_d = '0;
            row_d = '0;
        end
        if (pk_done) begin
            if (col_over || row_over) begin
                if (col_over) err_line_d  = 1'b1;
                if (row_over) err_frame_d = 1'b1;
            end else begin
                pix_valid_d = 1'b1;
                pix_data_d  = pk_word;
                pix_col_d   = col_q[COL_W-1:0];
                pix_row_d   = row_q[ROW_W-1:0];
                sof_d       = (col_q == '0) && (row_q == '0);
                eol_d       = (col_q == H_LAST);
            end
            // Column saturates at H_ACTIVE so an over-long line stays detectable at href fall.
            if (!col_over) col_d = col_q + CC_W'(1);
        end
        if (line_end) begin
            col_d = '0;
            if (!row_over) row_d = row_q + RC_W'(1);
            if (pk_partial || (col_q != H_END)) err_line_d = 1'b1;
        end
        if ((state_q == DONE) && (row_q != V_END)) err_frame_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            pix_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            pix_data_q  <= '0;
            pix_col_q   <= '0;
            pix_row_q   <= '0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pix_valid_q <= pix_valid_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            pix_data_q  <= pix_data_d;
            pix_col_q   <= pix_col_d;
            pix_row_q   <= pix_row_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_col    = pix_col_q;
    assign pix_row    = pix_row_q;
    assign pix_sof    = sof_q;
    assign pix_eol    = eol_q;
    assign err_line   = err_line_q;
    assign err_frame  = err_frame_q;
    assign frame_done = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule
